half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Registered 1-bit (parameterisable-width) half adder: bitwise sum = a XOR b, carry = a AND b.
- Adds a valid qualifier and a saturating carry-event counter.
- Leaf arithmetic block used as a building element in adder chains and as a datapath test primitive.
- Single clock domain, one-cycle latency.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (bit i of s/c depends only on bit i of a/b).
- CNT_W, 8, width of the carry-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cnt_clr  input  1  synchronous clear of carry_cnt.
- out_valid  output  1  s/c hold a result computed from a valid input.
- s  output  WIDTH  registered sum bits.
- c  output  WIDTH  registered carry bits.
- carry_cnt  output  CNT_W  number of accepted operations with any carry bit set, saturating.

Behaviour:
- Reset: asserting rst_n low immediately forces out_valid=0, s=0, c=0, carry_cnt=0, regardless of clk. Deassertion is synchronised by the user. The first capture occurs on the first rising edge with rst_n high.
- Per rising edge with in_valid=1:
  - s <= a ^ b; c <= a & b (per lane).
  - out_valid <= 1.
  - Latency is exactly 1 cycle.
- Per rising edge with in_valid=0:
  - out_valid <= 0.
  - s and c hold their previous values.
- Truth table per lane (a,b -> s,c): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
  - s and c are never both 1 in the same lane.
- No backpressure: every valid input is accepted, so back-to-back valid cycles produce back-to-back results.
- carry_cnt:
  - Increments by 1 on an edge where in_valid=1 and (a & b) != 0.
  - Saturates at 2^CNT_W-1 and does not wrap.
- cnt_clr:
  - cnt_clr=1 sets carry_cnt to 0 on the next edge.
  - cnt_clr has priority over a simultaneous increment, so the counter reads 0 afterwards.
- Reset mid-stream: an in-flight result is discarded (out_valid=0). No result appears after release until a new valid input is presented.
- X on a/b while in_valid=0 must not affect s, c or carry_cnt.

Optional Feature:
- Macro HALF_ADDER_PARITY_EN.
- Defined:
  - Adds output port sum_par (1 bit), registered alongside s, equal to the XOR-reduction of a ^ b.
  - Reset value 0; holds when in_valid=0.
- Not defined: port sum_par does not exist, and no parity logic is generated.

Test Plan:
- WIDTH=1, reset low then release. Apply a=0,b=0 / 0,1 / 1,0 / 1,1 with in_valid=1, one per 10 ns cycle. Required: one cycle later s,c = 0,0 / 1,0 / 1,0 / 0,1, out_valid high for 4 consecutive cycles, and carry_cnt=1 at the end.
- Drive in_valid=0 with a=1,b=1 for 3 cycles after a result s=1,c=0. Required: s=1, c=0 and carry_cnt unchanged; out_valid=0.
- WIDTH=4: a=4'b1100, b=4'b1010 -> s=4'b0110, c=4'b1000 one cycle later. If HALF_ADDER_PARITY_EN is defined, sum_par=0.
- CNT_W=2: apply 5 valid inputs with a=b=1 -> carry_cnt counts 1, 2, 3, 3, 3. Then cnt_clr=1 with a simultaneous carry input -> carry_cnt=0.
- Assert rst_n low mid-cycle while out_valid=1, s=0, c=1. Required: all outputs 0 immediately, without waiting for a clock edge.
- After release with in_valid=0, out_valid stays 0 until the next valid input.

Source files
------------

// File: rtl/half_adder_if.sv
// Operand/result bundle for half_adder; sum_par exists only when HALF_ADDER_PARITY_EN is defined.
interface half_adder_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cnt_clr;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic [CNT_W-1:0] carry_cnt;
`ifdef HALF_ADDER_PARITY_EN
  logic             sum_par;
`endif

  modport master (
    output in_valid, a, b, cnt_clr,
    input  out_valid, s, c, carry_cnt
`ifdef HALF_ADDER_PARITY_EN
    , input sum_par
`endif
  );

  modport slave (
    input  in_valid, a, b, cnt_clr,
    output out_valid, s, c, carry_cnt
`ifdef HALF_ADDER_PARITY_EN
    , output sum_par
`endif
  );
endinterface

// File: rtl/half_adder.sv
// Registered WIDTH-lane half adder with saturating carry-event counter; 1-cycle latency, no backpressure.
// Optional sum parity output enabled by HALF_ADDER_PARITY_EN.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  half_adder_if.slave ha
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_evt;

  // Gate on in_valid first so undriven operands on idle cycles cannot reach the counter.
  assign carry_evt = ha.in_valid && (|(ha.a & ha.b));

  always_comb begin
    vld_d = ha.in_valid;
    s_d   = s_q;
    c_d   = c_q;
    if (ha.in_valid) begin
      s_d = ha.a ^ ha.b;
      c_d = ha.a & ha.b;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ha.cnt_clr) begin
      cnt_d = '0;
    end else if (carry_evt && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      s_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      s_q   <= s_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

  assign ha.out_valid = vld_q;
  assign ha.s         = s_q;
  assign ha.c         = c_q;
  assign ha.carry_cnt = cnt_q;

`ifdef HALF_ADDER_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (ha.in_valid) begin
      par_d = ^(ha.a ^ ha.b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign ha.sum_par = par_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: directed scenarios plus random traffic against a lane-arithmetic model.
module tb_half_adder;
  localparam int W1 = 1;
  localparam int C1 = 2;
  localparam int W4 = 4;
  localparam int C4 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  half_adder_if #(.WIDTH(W1), .CNT_W(C1)) if1 ();
  half_adder_if #(.WIDTH(W4), .CNT_W(C4)) if4 ();

  half_adder #(.WIDTH(W1), .CNT_W(C1)) u_w1 (.clk(clk), .rst_n(rst_n), .ha(if1.slave));
  half_adder #(.WIDTH(W4), .CNT_W(C4)) u_w4 (.clk(clk), .rst_n(rst_n), .ha(if4.slave));

  int n_vec = 0;
  int n_err = 0;

  // Model state per instance: sum, carry, valid, counter, parity.
  int m1_s, m1_c, m1_v, m1_cnt, m1_par;
  int m4_s, m4_c, m4_v, m4_cnt, m4_par;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m1_s = 0; m1_c = 0; m1_v = 0; m1_cnt = 0; m1_par = 0;
    m4_s = 0; m4_c = 0; m4_v = 0; m4_cnt = 0; m4_par = 0;
  endtask

  // Each lane is an ordinary 1-bit addition: digit = (x+y) mod 2, carry = (x+y) div 2.
  task automatic model_step(input int width, input int cntw, input bit vld, input int a, input int b,
                            input bit clr, inout int ms, inout int mc, inout int mv,
                            inout int mcnt, inout int mpar);
    int lane_sum;
    int s_acc;
    int c_acc;
    int par;
    s_acc = 0; c_acc = 0; par = 0;
    if (vld) begin
      for (int i = 0; i < width; i++) begin
        lane_sum = ((a >> i) & 1) + ((b >> i) & 1);
        s_acc += (lane_sum % 2) << i;
        c_acc += (lane_sum / 2) << i;
        par = (par + lane_sum % 2) % 2;
      end
      ms = s_acc; mc = c_acc; mpar = par;
    end
    mv = vld ? 1 : 0;
    if (clr) mcnt = 0;
    else if (vld && c_acc != 0 && mcnt < (1 << cntw) - 1) mcnt = mcnt + 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".w1.vld"}, 32'(if1.out_valid), m1_v);
    chk({tag, ".w1.s"},   32'(if1.s),         m1_s);
    chk({tag, ".w1.c"},   32'(if1.c),         m1_c);
    chk({tag, ".w1.cnt"}, 32'(if1.carry_cnt), m1_cnt);
    chk({tag, ".w4.vld"}, 32'(if4.out_valid), m4_v);
    chk({tag, ".w4.s"},   32'(if4.s),         m4_s);
    chk({tag, ".w4.c"},   32'(if4.c),         m4_c);
    chk({tag, ".w4.cnt"}, 32'(if4.carry_cnt), m4_cnt);
`ifdef HALF_ADDER_PARITY_EN
    chk({tag, ".w1.par"}, 32'(if1.sum_par), m1_par);
    chk({tag, ".w4.par"}, 32'(if4.sum_par), m4_par);
`endif
  endtask

  // Called at a falling edge: drive, advance model, wait one cycle, check.
  task automatic apply(input string tag, input bit xin,
                       input bit v1, input int a1, input int b1, input bit cl1,
                       input bit v4, input int a4, input int b4, input bit cl4);
    int av1, bv1, av4, bv4;
    av1 = a1; bv1 = b1; av4 = a4; bv4 = b4;
    if1.in_valid = v1; if1.cnt_clr = cl1;
    if4.in_valid = v4; if4.cnt_clr = cl4;
    if (xin && !v1) begin if1.a = 'x; if1.b = 'x; end
    else begin if1.a = av1[0:0]; if1.b = bv1[0:0]; end
    if (xin && !v4) begin if4.a = 'x; if4.b = 'x; end
    else begin if4.a = av4[3:0]; if4.b = bv4[3:0]; end
    model_step(W1, C1, v1, a1, b1, cl1, m1_s, m1_c, m1_v, m1_cnt, m1_par);
    model_step(W4, C4, v4, a4, b4, cl4, m4_s, m4_c, m4_v, m4_cnt, m4_par);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int exp_s1[4];
    int exp_c1[4];
    int exp_cnt[5];
    exp_s1 = '{0, 1, 1, 0};
    exp_c1 = '{0, 0, 0, 1};
    exp_cnt = '{1, 2, 3, 3, 3};

    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cnt_clr = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cnt_clr = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Truth table, one per cycle, on the 1-lane instance.
    for (int i = 0; i < 4; i++) begin
      apply("tt", 1'b0, 1'b1, i >> 1, i & 1, 1'b0, 1'b0, 0, 0, 1'b0);
      chk("tt.s_const", 32'(if1.s), exp_s1[i]);
      chk("tt.c_const", 32'(if1.c), exp_c1[i]);
      chk("tt.vld_const", 32'(if1.out_valid), 1);
    end
    chk("tt.cnt_end", 32'(if1.carry_cnt), 1);

    // Hold: result s=1,c=0 then idle cycles with a=b=1 on the bus.
    apply("hold_pre", 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply("hold", 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 15, 15, 1'b0);
      chk("hold.s_const", 32'(if1.s), 1);
      chk("hold.c_const", 32'(if1.c), 0);
      chk("hold.cnt_const", 32'(if1.carry_cnt), 1);
      chk("hold.vld_const", 32'(if1.out_valid), 0);
    end

    // Multi-lane vector.
    apply("w4", 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 12, 10, 1'b0);
    chk("w4.s_const", 32'(if4.s), 6);
    chk("w4.c_const", 32'(if4.c), 8);
`ifdef HALF_ADDER_PARITY_EN
    chk("w4.par_const", 32'(if4.sum_par), 0);
`endif

    // Saturation on the 2-bit counter, then clear beating a carry.
    apply("clr0", 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply("sat", 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 0, 0, 1'b0);
      chk("sat.cnt_const", 32'(if1.carry_cnt), exp_cnt[i]);
    end
    apply("clr_pri", 1'b0, 1'b1, 1, 1, 1'b1, 1'b1, 3, 3, 1'b1);
    chk("clr_pri.cnt_const", 32'(if1.carry_cnt), 0);

    // Random traffic; idle cycles carry X operands.
    for (int n = 0; n < 300; n++) begin
      apply("rnd", 1'b1,
            1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset while a carry result is on the outputs.
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.cnt_clr = 1'b0;
    if4.in_valid = 1'b1; if4.a = 4'h3; if4.b = 4'h1; if4.cnt_clr = 1'b0;
    model_step(W1, C1, 1'b1, 1, 1, 1'b0, m1_s, m1_c, m1_v, m1_cnt, m1_par);
    model_step(W4, C4, 1'b1, 3, 1, 1'b0, m4_s, m4_c, m4_v, m4_cnt, m4_par);
    @(posedge clk);
    #2;
    check_all("pre_rst");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    chk("rst_async.vld_const", 32'(if1.out_valid), 0);
    chk("rst_async.c_const", 32'(if1.c), 0);
    if1.in_valid = 1'b0; if4.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply("post_rst", 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 15, 15, 1'b0);
      chk("post_rst.vld_const", 32'(if1.out_valid), 0);
    end
    apply("post_rst_vld", 1'b0, 1'b1, 0, 1, 1'b0, 1'b1, 5, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
